// File: rtl/ring_fifo_if.sv
// Valid/ready bus pair for ring_fifo.
//   in_valid/in_ready/in_data    : producer -> FIFO write handshake
//   out_valid/out_ready/out_data : FIFO -> consumer show-ahead read handshake
// Modports: slave = FIFO side, master = producer/consumer side.
interface ring_fifo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ring_fifo.sv
// Circular FIFO, show-ahead read, any DEPTH >= 2, single clock domain.
// Ports:
//   clock, reset     : posedge clock, synchronous active-high reset
//   flush            : synchronous clear of pointers, count and overflow
//   bus (slave)      : in_valid/in_ready/in_data write side,
//                      out_valid/out_ready/out_data read side (out_data = oldest entry)
//   count            : occupancy 0..DEPTH
//   full/almost_full : count == DEPTH / count >= AFULL_LVL
//   overflow         : sticky, set when an entry is dropped (OVERWRITE=1 only)
//   ovf_clr          : clears overflow; a drop in the same cycle wins
module ring_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 512,
  parameter bit          OVERWRITE = 1'b1,
  parameter int          AFULL_LVL = int'(DEPTH) - 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  ring_fifo_if.slave                 bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push, pop, drop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (int'(count_q) >= AFULL_LVL);
  assign count       = count_q;
  assign overflow    = overflow_q;

  // in_ready never looks at out_ready: a full FIFO in backpressure mode refuses a push
  // even while it is being popped.
  assign bus.in_ready  = OVERWRITE ? 1'b1 : !full;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem[rd_ptr_q];

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  // Only reachable with OVERWRITE=1, since in_ready is low when full otherwise.
  assign drop = push & !pop & full;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push)        wr_ptr_d = ptr_inc(wr_ptr_q);
      // A drop retires the oldest entry, so the read pointer follows the write pointer.
      if (pop || drop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop && !full)   count_d = count_q + CW'(1);
      else if (pop && !push)       count_d = count_q - CW'(1);
      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; only the pointers and count are.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) mem[wr_ptr_q] <= bus.in_data;
  end

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo: three instances (depth 4 overwrite, depth 4 backpressure,
// depth 5 overwrite) driven one at a time from a single stimulus process.
module tb_ring_fifo;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int vecs = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Instance A: DEPTH 4, overwrite
  ring_fifo_if #(.WIDTH(8)) a_if ();
  logic       a_flush, a_ovf_clr, a_full, a_afull, a_ovf;
  logic [2:0] a_count;
  ring_fifo #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1'b1), .AFULL_LVL(3)) u_a (
    .clock(clock), .reset(reset), .flush(a_flush), .bus(a_if), .count(a_count),
    .full(a_full), .almost_full(a_afull), .overflow(a_ovf), .ovf_clr(a_ovf_clr)
  );

  // Instance B: DEPTH 4, backpressure
  ring_fifo_if #(.WIDTH(8)) b_if ();
  logic       b_flush, b_ovf_clr, b_full, b_afull, b_ovf;
  logic [2:0] b_count;
  ring_fifo #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1'b0), .AFULL_LVL(3)) u_b (
    .clock(clock), .reset(reset), .flush(b_flush), .bus(b_if), .count(b_count),
    .full(b_full), .almost_full(b_afull), .overflow(b_ovf), .ovf_clr(b_ovf_clr)
  );

  // Instance C: DEPTH 5 (non power of two), overwrite
  ring_fifo_if #(.WIDTH(8)) c_if ();
  logic       c_flush, c_ovf_clr, c_full, c_afull, c_ovf;
  logic [2:0] c_count;
  ring_fifo #(.WIDTH(8), .DEPTH(5), .OVERWRITE(1'b1), .AFULL_LVL(4)) u_c (
    .clock(clock), .reset(reset), .flush(c_flush), .bus(c_if), .count(c_count),
    .full(c_full), .almost_full(c_afull), .overflow(c_ovf), .ovf_clr(c_ovf_clr)
  );

  initial begin
    reset = 1'b1;
    a_flush = 0; a_ovf_clr = 0; a_if.in_valid = 0; a_if.in_data = 0; a_if.out_ready = 0;
    b_flush = 0; b_ovf_clr = 0; b_if.in_valid = 0; b_if.in_data = 0; b_if.out_ready = 0;
    c_flush = 0; c_ovf_clr = 0; c_if.in_valid = 0; c_if.in_data = 0; c_if.out_ready = 0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_count",    32'(a_count), 0);
    check("rst_out_valid", 32'(a_if.out_valid), 0);
    check("rst_full",     32'(a_full), 0);
    check("rst_afull",    32'(a_afull), 0);
    check("rst_ovf",      32'(a_ovf), 0);
    check("rst_in_ready", 32'(a_if.in_ready), 1);
    check("rst_b_in_ready", 32'(b_if.in_ready), 1);

    // 1. Push three, then pop three in order
    begin
      logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) begin
        a_if.in_valid = 1; a_if.in_data = vals[i];
        step();
      end
      a_if.in_valid = 0;
      check("t1_count", 32'(a_count), 3);
      check("t1_head",  32'(a_if.out_data), 32'h11);
      check("t1_afull", 32'(a_afull), 1);
      a_if.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
        check("t1_pop", 32'(a_if.out_data), 32'(vals[i]));
        step();
      end
      a_if.out_ready = 0;
      check("t1_empty", 32'(a_if.out_valid), 0);
      check("t1_count0", 32'(a_count), 0);
    end

    // 2. Overwrite: push 1..6 into depth 4, oldest two dropped
    for (int i = 1; i <= 6; i++) begin
      a_if.in_valid = 1; a_if.in_data = 8'(i);
      step();
    end
    a_if.in_valid = 0;
    check("t2_count", 32'(a_count), 4);
    check("t2_full",  32'(a_full), 1);
    check("t2_ovf",   32'(a_ovf), 1);
    a_if.out_ready = 1;
    for (int i = 3; i <= 6; i++) begin
      check("t2_pop", 32'(a_if.out_data), 32'(i));
      step();
    end
    a_if.out_ready = 0;
    check("t2_empty", 32'(a_if.out_valid), 0);
    check("t2_ovf_sticky", 32'(a_ovf), 1);

    // 5. ovf_clr, full push+pop without overflow, clear vs drop priority
    a_ovf_clr = 1;
    step();
    a_ovf_clr = 0;
    check("t5_ovf_clr", 32'(a_ovf), 0);
    for (int i = 7; i <= 10; i++) begin
      a_if.in_valid = 1; a_if.in_data = 8'(i);
      step();
    end
    check("t5_full", 32'(a_full), 1);
    a_if.in_data = 8'h0B; a_if.out_ready = 1;
    check("t5_head", 32'(a_if.out_data), 7);
    step();
    a_if.out_ready = 0;
    check("t5_pp_count", 32'(a_count), 4);
    check("t5_pp_ovf",   32'(a_ovf), 0);
    check("t5_pp_head",  32'(a_if.out_data), 8);
    a_if.in_data = 8'h0C; a_ovf_clr = 1;
    step();
    a_if.in_valid = 0; a_ovf_clr = 0;
    check("t5_set_wins", 32'(a_ovf), 1);
    check("t5_drop_head", 32'(a_if.out_data), 9);
    check("t5_drop_count", 32'(a_count), 4);

    // 6. Flush with push asserted, then first-push latency, then reset
    a_flush = 1; a_if.in_valid = 1; a_if.in_data = 8'hDD;
    step();
    a_flush = 0; a_if.in_valid = 0;
    check("t6_fl_count", 32'(a_count), 0);
    check("t6_fl_valid", 32'(a_if.out_valid), 0);
    check("t6_fl_ovf",   32'(a_ovf), 0);
    check("t6_fl_full",  32'(a_full), 0);
    check("t6_fl_ready", 32'(a_if.in_ready), 1);
    // Push into empty with out_ready high: no bypass, entry must remain
    a_if.in_valid = 1; a_if.in_data = 8'h44; a_if.out_ready = 1;
    step();
    a_if.in_valid = 0; a_if.out_ready = 0;
    check("t6_lat_count", 32'(a_count), 1);
    check("t6_lat_data",  32'(a_if.out_data), 32'h44);
    reset = 1;
    step();
    reset = 0;
    check("t6_rst_count", 32'(a_count), 0);
    check("t6_rst_valid", 32'(a_if.out_valid), 0);

    // 3. Backpressure: push 1..6 into depth 4, last two refused
    for (int i = 1; i <= 6; i++) begin
      b_if.in_valid = 1; b_if.in_data = 8'(i);
      check("t3_in_ready", 32'(b_if.in_ready), (i <= 4) ? 1 : 0);
      step();
    end
    check("t3_count", 32'(b_count), 4);
    check("t3_full",  32'(b_full), 1);
    check("t3_ovf",   32'(b_ovf), 0);
    // Full + pop + in_valid: push still refused this cycle
    b_if.in_data = 8'h77; b_if.out_ready = 1;
    check("t3_no_comb_ready", 32'(b_if.in_ready), 0);
    check("t3_pop", 32'(b_if.out_data), 1);
    step();
    b_if.in_valid = 0;
    check("t3_pop_count", 32'(b_count), 3);
    for (int i = 2; i <= 4; i++) begin
      check("t3_pop", 32'(b_if.out_data), 32'(i));
      step();
    end
    b_if.out_ready = 0;
    check("t3_empty", 32'(b_if.out_valid), 0);

    // 4. Depth 5: preload two, then 20 cycles of push+pop across the wrap
    c_if.in_valid = 1;
    c_if.in_data = 8'h50;
    step();
    c_if.in_data = 8'h51;
    step();
    c_if.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      c_if.in_data = 8'(8'h52 + i);
      check("t4_data", 32'(c_if.out_data), 32'(8'h50 + i));
      step();
      check("t4_count", 32'(c_count), 2);
    end
    c_if.in_valid = 0; c_if.out_ready = 0;
    check("t4_head_end", 32'(c_if.out_data), 32'h64);
    check("t4_ovf", 32'(c_ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
